// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
//   Shared definitions for the calculator keypad consumers: key-code
//   constants, the operand-entry state type and the BCD digit shift helper.
// ----------------------------------------------------------------------------
package calc_pkg;

    localparam logic [3:0] KEY_DIGIT_MAX  = 4'h9;
    localparam logic [3:0] KEY_ENTER_CODE = 4'hA;
    localparam logic [3:0] KEY_CLEAR_CODE = 4'hC;

    // Widest operand the shift helper supports (16 BCD digits).
    localparam int unsigned MAX_OP_W = 64;

    typedef enum logic {
        ENTRY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Shift a new BCD digit into the least significant nibble. Callers cast
    // the result down to their own operand width, which discards the digit
    // shifted out of the top.
    function automatic logic [MAX_OP_W-1:0] bcd_shift_in(
        input logic [MAX_OP_W-1:0] op,
        input logic [3:0]          digit
    );
        return {op[MAX_OP_W-5:0], digit};
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// ----------------------------------------------------------------------------
// key_edge_det
//   Registers a key-pressed level and produces a single-cycle pulse on its
//   rising edge, so a long key hold yields exactly one event.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   stb_i  : key-pressed level, synchronous to clk_i
//   evt_o  : one-cycle pulse, high in the first cycle stb_i is seen high
// ----------------------------------------------------------------------------
module key_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic stb_i,
    output logic evt_o
);

    logic stb_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stb_q <= 1'b0;
        end else begin
            stb_q <= stb_i;
        end
    end

    assign evt_o = stb_i & ~stb_q;

endmodule

// File: rtl/operand_store.sv
// ----------------------------------------------------------------------------
// operand_store
//   Collects NUM_OPS multi-digit BCD operands from keypad events and holds
//   them packed for the arithmetic unit until acknowledged.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   key_code  : keypad code, valid while key_stb is high
//   key_stb   : key-pressed level (may be held for many cycles)
//   ops_ack   : consumer accepts the operands (single-cycle pulse)
//   operands  : packed BCD operands, operand 0 in the LSBs
//   op_idx    : index of the operand under entry
//   digit_cnt : digits entered in the current operand
//   ops_valid : all operands entered and held
//   ovf       : sticky, a digit was dropped because the operand was full
// ----------------------------------------------------------------------------
module operand_store
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned NUM_OPS   = 2,
    parameter logic [3:0]  KEY_ENTER = KEY_ENTER_CODE,
    parameter logic [3:0]  KEY_CLEAR = KEY_CLEAR_CODE,
    localparam int unsigned OP_W     = 4 * DIGITS,
    localparam int unsigned IDX_W    = $clog2(NUM_OPS),
    localparam int unsigned CNT_W    = $clog2(DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              key_code,
    input  logic                    key_stb,
    input  logic                    ops_ack,
    output logic [NUM_OPS*OP_W-1:0] operands,
    output logic [IDX_W-1:0]        op_idx,
    output logic [CNT_W-1:0]        digit_cnt,
    output logic                    ops_valid,
    output logic                    ovf
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OPS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);

    logic key_evt;

    key_edge_det u_key_edge (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .stb_i  (key_stb),
        .evt_o  (key_evt)
    );

    state_e                       state_q;
    logic [NUM_OPS-1:0][OP_W-1:0] ops_q;
    logic [IDX_W-1:0]             op_idx_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         valid_q;
    logic                         ovf_q;

    logic [OP_W-1:0] shifted_d;
    logic            is_digit;
    logic            is_enter;
    logic            is_clear;
    logic            restart;

    assign is_digit  = (key_code <= KEY_DIGIT_MAX);
    assign is_enter  = (key_code == KEY_ENTER);
    assign is_clear  = (key_code == KEY_CLEAR);
    assign shifted_d = OP_W'(bcd_shift_in(MAX_OP_W'(ops_q[op_idx_q]), key_code));

    // Clear and acknowledge both return to the reset image; any key that
    // coincides with an accepted ack is dropped rather than starting the
    // next transaction.
    assign restart = (key_evt && is_clear) || ((state_q == FULL) && ops_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ENTRY;
            ops_q    <= '0;
            op_idx_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (restart) begin
            state_q  <= ENTRY;
            ops_q    <= '0;
            op_idx_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (key_evt && (state_q == ENTRY)) begin
            if (is_digit) begin
                if (cnt_q < CNT_FULL) begin
                    ops_q[op_idx_q] <= shifted_d;
                    cnt_q           <= cnt_q + CNT_W'(1);
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (is_enter) begin
                if (op_idx_q < IDX_LAST) begin
                    op_idx_q <= op_idx_q + IDX_W'(1);
                    cnt_q    <= '0;
                end else begin
                    valid_q <= 1'b1;
                    state_q <= FULL;
                end
            end
        end
    end

    assign operands  = ops_q;
    assign op_idx    = op_idx_q;
    assign digit_cnt = cnt_q;
    assign ops_valid = valid_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/operand_store.md
Name: operand_store

Overview:
- Parametrised, clocked successor to the two-operand keypad latch in the calculator datapath.
- Collects NUM_OPS multi-digit BCD operands from debounced keypad key events and presents them packed to the arithmetic unit.
- Handshakes with the consumer through ops_valid/ops_ack.
- Sits between the keypad decoder and the ALU/display blocks.

Parameters:
- DIGITS, 2, max BCD digits per operand; operand width OP_W = 4*DIGITS.
- NUM_OPS, 2, operands collected per transaction (>=2).
- KEY_ENTER, 4'hA, key code that closes the current operand.
- KEY_CLEAR, 4'hC, key code that clears everything.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- key_code  in  4  keypad code, valid while key_stb high.
- key_stb  in  1  key-pressed level, synchronous to clk, may stay high for many cycles.
- ops_ack  in  1  consumer accepts operands; single-cycle pulse.
- operands  out  NUM_OPS*OP_W  packed BCD operands; operand 0 in the LSBs.
- op_idx  out  $clog2(NUM_OPS)  index of the operand under entry.
- digit_cnt  out  $clog2(DIGITS+1)  digits entered in the current operand.
- ops_valid  out  1  all operands entered, held for the consumer.
- ovf  out  1  sticky: a digit was dropped because the operand was full.

Behaviour:
- Reset (async, rst_n low): operands=0, op_idx=0, digit_cnt=0, ops_valid=0, ovf=0, key_stb_q=0, state=ENTRY.
- Key event
  - key_evt = key_stb & ~key_stb_q, where key_stb_q is key_stb registered.
  - One event per press, whatever the hold time.
  - All register updates land on the clk edge at which key_evt is high, i.e. 1-cycle latency from the first cycle key_stb is sampled high.
- FSM states: ENTRY, FULL.
- ENTRY, digit event (key_code 0-9):
  - If digit_cnt < DIGITS: operand[op_idx] = {operand[op_idx][OP_W-5:0], key_code}; digit_cnt++.
  - Otherwise: digit dropped, ovf=1, operand unchanged.
- ENTRY, KEY_ENTER:
  - If op_idx < NUM_OPS-1: op_idx++, digit_cnt=0.
  - If op_idx == NUM_OPS-1: ops_valid=1, state=FULL; op_idx and digit_cnt hold.
  - Enter with digit_cnt=0 is legal; that operand stays 0.
- ENTRY, other codes (not 0-9, not KEY_ENTER/KEY_CLEAR): ignored.
- FULL:
  - Digit and enter events are ignored; operands stay stable while ops_valid=1.
  - ops_ack=1: all registers take reset values, state=ENTRY, on that edge.
  - ops_ack is ignored in ENTRY.
- KEY_CLEAR, any state: all registers to reset values, state=ENTRY.
- Simultaneous events:
  - ops_ack with any key_evt in FULL: result is identical to reset values; the key is discarded, not applied to the new transaction.
  - key_stb held across a clear/ack: no new event until it drops and rises again.
- Reset mid-entry: everything clears immediately (async); the first key after rst_n deasserts goes to operand 0.
- Widths: op_idx never exceeds NUM_OPS-1; digit_cnt never exceeds DIGITS. No binary conversion; operands stay BCD.

Decomposition:
- Shared calc_pkg holds:
  - KEY_ENTER, KEY_CLEAR and other key-code constants.
  - State enum {ENTRY, FULL}.
  - Function for the OP_W digit shift.
- One natural sub-module: key_edge_det (key_stb register plus rising-edge pulse), reused by other keypad consumers.
- Operand array, counters and FSM stay in operand_store.

Test Plan:
- Reset then keys 1,2,ENTER,3,4,ENTER (defaults), each key_stb held 5 cycles:
  - operands=16'h3412.
  - ops_valid=1 one cycle after the final ENTER rise.
  - op_idx=1, ovf=0.
- Key 7 held high for 20 cycles: exactly one digit captured (operand0=8'h07, digit_cnt=1).
- Keys 1,2,3 in operand 0: third digit dropped, operand0=8'h12, ovf=1. ovf stays 1 through ENTER; KEY_CLEAR returns ovf=0, operands=0.
- In FULL, press 9 and ENTER:
  - operands unchanged.
  - ops_ack pulse clears everything next edge: ops_valid=0, op_idx=0, state ENTRY.
- ops_ack coincident with a digit 5 rise in FULL: all outputs=0 after the edge, digit 5 not stored.
- rst_n low mid-operand-1 entry (asynchronous, between clk edges): outputs zero without a clock edge. Parameter sweep NUM_OPS=3, DIGITS=3 with 1,ENTER,22,ENTER,333,ENTER → operands=36'h333_022_001.
